// File: rtl/fpu_dispatch_arb_if.sv
// Bundle of the FPU dispatch/response handshake signals.
// The master side is the issue port, the sub-core model and the output sink.
// The slave side is fpu_dispatch_arb.
//   valid_in/ready_in/core_sel_in/tag_in/req_data_in : request from the issue port
//   core_valid/core_ready/core_tag/core_data         : request fan-out to sub-cores
//   rsp_valid/rsp_ready/rsp_tag/rsp_data             : per-core responses, core 0 in the LSBs
//   valid_out/ready_out/tag_out/data_out/core_out    : merged response stream
//   bad_sel                                          : sticky illegal-selector flag
interface fpu_dispatch_arb_if #(
  parameter int unsigned NUM_FPC = 3,
  parameter int unsigned TAGW    = 2,
  parameter int unsigned REQ_W   = 384,
  parameter int unsigned RSP_W   = 134
);
  localparam int unsigned SELW = (NUM_FPC > 1) ? $clog2(NUM_FPC) : 1;

  logic                     valid_in;
  logic                     ready_in;
  logic [SELW-1:0]          core_sel_in;
  logic [TAGW-1:0]          tag_in;
  logic [REQ_W-1:0]         req_data_in;

  logic [NUM_FPC-1:0]       core_valid;
  logic [NUM_FPC-1:0]       core_ready;
  logic [TAGW-1:0]          core_tag;
  logic [REQ_W-1:0]         core_data;

  logic [NUM_FPC-1:0]       rsp_valid;
  logic [NUM_FPC-1:0]       rsp_ready;
  logic [NUM_FPC*TAGW-1:0]  rsp_tag;
  logic [NUM_FPC*RSP_W-1:0] rsp_data;

  logic                     valid_out;
  logic                     ready_out;
  logic [TAGW-1:0]          tag_out;
  logic [RSP_W-1:0]         data_out;
  logic [SELW-1:0]          core_out;
  logic                     bad_sel;

  modport master (
    output valid_in, core_sel_in, tag_in, req_data_in,
    input  ready_in,
    input  core_valid, core_tag, core_data,
    output core_ready,
    output rsp_valid, rsp_tag, rsp_data,
    input  rsp_ready,
    input  valid_out, tag_out, data_out, core_out, bad_sel,
    output ready_out
  );

  modport slave (
    input  valid_in, core_sel_in, tag_in, req_data_in,
    output ready_in,
    output core_valid, core_tag, core_data,
    input  core_ready,
    input  rsp_valid, rsp_tag, rsp_data,
    output rsp_ready,
    output valid_out, tag_out, data_out, core_out, bad_sel,
    input  ready_out
  );
endinterface

// File: rtl/fpu_dispatch_arb.sv
// Dispatch requests to one of NUM_FPC FP sub-cores and merge their responses
// onto one registered output. Completion is round-robin (ORDERED=0) or in issue
// order (ORDERED=1), where the issue order is tracked by a FIFO of core indices.
// Ports:
//   clk   : clock
//   reset : asynchronous, active-low reset
//   bus   : fpu_dispatch_arb_if slave (request, core, response and output channels)
module fpu_dispatch_arb #(
  parameter int unsigned NUM_FPC = 3,
  parameter int unsigned TAGW    = 2,
  parameter int unsigned REQ_W   = 384,
  parameter int unsigned RSP_W   = 134,
  parameter int unsigned ORDERED = 0,
  parameter int unsigned DEPTH   = 8
) (
  input  logic               clk,
  input  logic               reset,
  fpu_dispatch_arb_if.slave  bus
);
  localparam int unsigned SELW = (NUM_FPC > 1) ? $clog2(NUM_FPC) : 1;
  localparam int unsigned PTRW = $clog2(DEPTH);
  localparam int unsigned CNTW = PTRW + 1;

  logic [SELW-1:0]    r_ord_mem [DEPTH];
  logic [PTRW-1:0]    r_wr_ptr;
  logic [PTRW-1:0]    r_rd_ptr;
  logic [CNTW-1:0]    r_count;
  logic [SELW-1:0]    r_rr;
  logic               r_out_valid;
  logic [TAGW-1:0]    r_tag_out;
  logic [RSP_W-1:0]   r_data_out;
  logic [SELW-1:0]    r_core_out;
  logic               r_bad_sel;

  logic               w_sel_legal;
  logic               w_sel_ready;
  logic               w_ord_full;
  logic               w_ready_in;
  logic [NUM_FPC-1:0] w_core_valid;
  logic               w_push;
  logic               w_pop;
  logic               w_can_load;
  logic               w_grant_vld;
  logic [SELW-1:0]    w_grant;
  logic [SELW-1:0]    w_idx;
  logic [SELW-1:0]    w_head;
  logic [NUM_FPC-1:0] w_rsp_ready;
  logic               w_rsp_hs;
  logic [TAGW-1:0]    w_rsp_tag;
  logic [RSP_W-1:0]   w_rsp_data;

  assign w_sel_legal = (32'(bus.core_sel_in) < NUM_FPC);
  assign w_ord_full  = (ORDERED != 0) && (32'(r_count) == DEPTH);

  // Request fan-out; an out-of-range selector matches no core and is never accepted.
  always_comb begin : dispatch
    w_sel_ready  = 1'b0;
    w_core_valid = '0;
    for (int unsigned i = 0; i < NUM_FPC; i++) begin
      if (32'(bus.core_sel_in) == i) begin
        w_sel_ready     = bus.core_ready[i];
        w_core_valid[i] = bus.valid_in && !w_ord_full && reset;
      end
    end
  end

  assign w_ready_in = reset && w_sel_legal && w_sel_ready && !w_ord_full;
  assign w_push     = (ORDERED != 0) && bus.valid_in && w_ready_in;
  assign w_can_load = !r_out_valid || bus.ready_out;

  // Response grant: FIFO head in ordered mode, else first valid core at or after r_rr.
  always_comb begin : arbitrate
    w_grant_vld = 1'b0;
    w_grant     = '0;
    w_idx       = '0;
    w_head      = r_ord_mem[r_rd_ptr];
    if (ORDERED != 0) begin
      if ((r_count != '0) && bus.rsp_valid[w_head]) begin
        w_grant_vld = 1'b1;
        w_grant     = w_head;
      end
    end else begin
      for (int unsigned k = 0; k < NUM_FPC; k++) begin
        w_idx = SELW'((32'(r_rr) + k) % NUM_FPC);
        if (!w_grant_vld && bus.rsp_valid[w_idx]) begin
          w_grant_vld = 1'b1;
          w_grant     = w_idx;
        end
      end
    end
    w_rsp_ready = '0;
    if (w_grant_vld) w_rsp_ready[w_grant] = w_can_load;
  end

  assign w_rsp_hs   = w_grant_vld && w_can_load;
  assign w_pop      = (ORDERED != 0) && w_rsp_hs;
  assign w_rsp_tag  = bus.rsp_tag[32'(w_grant)*TAGW +: TAGW];
  assign w_rsp_data = bus.rsp_data[32'(w_grant)*RSP_W +: RSP_W];

  // Output register, round-robin pointer, order FIFO and sticky error flag.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_out_valid <= 1'b0;
      r_tag_out   <= '0;
      r_data_out  <= '0;
      r_core_out  <= '0;
      r_bad_sel   <= 1'b0;
      r_rr        <= '0;
      r_wr_ptr    <= '0;
      r_rd_ptr    <= '0;
      r_count     <= '0;
      for (int unsigned d = 0; d < DEPTH; d++) r_ord_mem[d] <= '0;
    end else begin
      if (w_rsp_hs) begin
        r_out_valid <= 1'b1;
        r_tag_out   <= w_rsp_tag;
        r_data_out  <= w_rsp_data;
        r_core_out  <= w_grant;
      end else if (bus.ready_out) begin
        r_out_valid <= 1'b0;
      end

      if (bus.valid_in && !w_sel_legal) r_bad_sel <= 1'b1;

      if ((ORDERED == 0) && w_rsp_hs)
        r_rr <= (32'(w_grant) == NUM_FPC - 1) ? '0 : w_grant + SELW'(1);

      if (w_push) begin
        r_ord_mem[r_wr_ptr] <= bus.core_sel_in;
        r_wr_ptr            <= r_wr_ptr + PTRW'(1);
      end
      if (w_pop) r_rd_ptr <= r_rd_ptr + PTRW'(1);

      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CNTW'(1);
        2'b01:   r_count <= r_count - CNTW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  assign bus.ready_in   = w_ready_in;
  assign bus.core_valid = w_core_valid;
  assign bus.core_tag   = bus.tag_in;
  assign bus.core_data  = REQ_W'(bus.req_data_in);
  assign bus.rsp_ready  = w_rsp_ready;
  assign bus.valid_out  = r_out_valid;
  assign bus.tag_out    = r_tag_out;
  assign bus.data_out   = r_data_out;
  assign bus.core_out   = r_core_out;
  assign bus.bad_sel    = r_bad_sel;
endmodule

// File: tb/tb_fpu_dispatch_arb.sv
// Directed bench for fpu_dispatch_arb: one round-robin instance (u_rr) and one
// ordered instance with a 4-deep order FIFO (u_ord), sharing clock and reset.
module tb_fpu_dispatch_arb;
  localparam int unsigned NUM_FPC = 3;
  localparam int unsigned TAGW    = 2;
  localparam int unsigned REQ_W   = 384;
  localparam int unsigned RSP_W   = 134;

  logic clk = 1'b0;
  logic reset;
  int   n_cmp = 0;
  int   n_err = 0;

  always #5 clk = ~clk;

  fpu_dispatch_arb_if #(.NUM_FPC(NUM_FPC), .TAGW(TAGW), .REQ_W(REQ_W), .RSP_W(RSP_W)) if_rr ();
  fpu_dispatch_arb_if #(.NUM_FPC(NUM_FPC), .TAGW(TAGW), .REQ_W(REQ_W), .RSP_W(RSP_W)) if_ord ();

  fpu_dispatch_arb #(.NUM_FPC(NUM_FPC), .TAGW(TAGW), .REQ_W(REQ_W), .RSP_W(RSP_W),
                     .ORDERED(0), .DEPTH(8)) u_rr (
    .clk(clk), .reset(reset), .bus(if_rr)
  );

  fpu_dispatch_arb #(.NUM_FPC(NUM_FPC), .TAGW(TAGW), .REQ_W(REQ_W), .RSP_W(RSP_W),
                     .ORDERED(1), .DEPTH(4)) u_ord (
    .clk(clk), .reset(reset), .bus(if_ord)
  );

  task automatic chk(input string name, input logic [255:0] obs, input logic [255:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", name, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b0;
    if_rr.valid_in = 1'b1;  if_rr.core_sel_in = '0;  if_rr.tag_in = '0;
    if_rr.req_data_in = '0; if_rr.core_ready = 3'b111; if_rr.rsp_valid = '0;
    if_rr.rsp_tag = '0;     if_rr.rsp_data = '0;     if_rr.ready_out = 1'b0;
    if_ord.valid_in = 1'b0; if_ord.core_sel_in = '0; if_ord.tag_in = '0;
    if_ord.req_data_in = '0; if_ord.core_ready = '0; if_ord.rsp_valid = '0;
    if_ord.rsp_tag = {2'd2, 2'd1, 2'd0};
    if_ord.rsp_data = {RSP_W'(32'hE002), RSP_W'(32'hE001), RSP_W'(32'hE000)};
    if_ord.ready_out = 1'b0;

    // Reset values; dispatch blocked while reset is held.
    repeat (2) tick();
    chk("rst_valid_out", 256'(if_rr.valid_out), 256'(0));
    chk("rst_tag_out",   256'(if_rr.tag_out), 256'(0));
    chk("rst_data_out",  256'(if_rr.data_out), 256'(0));
    chk("rst_core_out",  256'(if_rr.core_out), 256'(0));
    chk("rst_bad_sel",   256'(if_rr.bad_sel), 256'(0));
    chk("rst_ready_in",  256'(if_rr.ready_in), 256'(0));
    chk("rst_core_valid", 256'(if_rr.core_valid), 256'(0));
    reset = 1'b1;
    if_rr.valid_in = 1'b0;

    // Round-robin with all cores valid: core_out 0,1,2,0,1 back to back.
    if_rr.rsp_valid = 3'b111;
    if_rr.ready_out = 1'b1;
    if_rr.rsp_tag   = {2'd2, 2'd1, 2'd0};
    if_rr.rsp_data  = {RSP_W'(32'hD002), RSP_W'(32'hD001), RSP_W'(32'hD000)};
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("rr_valid_out", 256'(if_rr.valid_out), 256'(1));
      chk("rr_core_out",  256'(if_rr.core_out), 256'(i % 3));
      chk("rr_tag_out",   256'(if_rr.tag_out), 256'(i % 3));
      chk("rr_data_out",  256'(if_rr.data_out), 256'(32'hD000 + (i % 3)));
    end
    if_rr.rsp_valid = 3'b000;
    tick();
    chk("rr_drain_valid_out", 256'(if_rr.valid_out), 256'(0));

    // Output stall: register holds, no rsp_ready while full and blocked.
    if_rr.ready_out = 1'b0;
    if_rr.rsp_valid = 3'b001;
    if_rr.rsp_tag   = {2'd2, 2'd1, 2'd2};
    #1;
    chk("hold_rsp_ready_empty", 256'(if_rr.rsp_ready), 256'(3'b001));
    tick();
    chk("hold_core_out", 256'(if_rr.core_out), 256'(0));
    if_rr.rsp_tag = {2'd2, 2'd1, 2'd3};
    if_rr.rsp_data[0 +: RSP_W] = RSP_W'(32'hD0FF);
    for (int c = 0; c < 3; c++) begin
      #1;
      chk("hold_valid_out", 256'(if_rr.valid_out), 256'(1));
      chk("hold_tag_out",   256'(if_rr.tag_out), 256'(2));
      chk("hold_data_out",  256'(if_rr.data_out), 256'(32'hD000));
      chk("hold_rsp_ready", 256'(if_rr.rsp_ready), 256'(0));
      tick();
    end
    if_rr.ready_out = 1'b1;
    #1;
    chk("release_rsp_ready", 256'(if_rr.rsp_ready), 256'(3'b001));
    tick();
    chk("reload_valid_out", 256'(if_rr.valid_out), 256'(1));
    chk("reload_tag_out",   256'(if_rr.tag_out), 256'(3));
    chk("reload_data_out",  256'(if_rr.data_out), 256'(32'hD0FF));
    if_rr.rsp_valid = 3'b000;
    tick();
    chk("reload_drain", 256'(if_rr.valid_out), 256'(0));

    // Legal dispatch and pass-through.
    if_rr.valid_in = 1'b1;
    if_rr.core_sel_in = 2'd1;
    if_rr.tag_in = 2'd3;
    if_rr.req_data_in = {REQ_W{1'b0}} | REQ_W'(64'hCAFE_F00D_1234_5678);
    if_rr.core_ready = 3'b010;
    #1;
    chk("disp_ready_in",   256'(if_rr.ready_in), 256'(1));
    chk("disp_core_valid", 256'(if_rr.core_valid), 256'(3'b010));
    chk("disp_core_tag",   256'(if_rr.core_tag), 256'(3));
    chk("disp_core_data",  256'(if_rr.core_data), 256'(64'hCAFE_F00D_1234_5678));
    if_rr.core_ready = 3'b101;
    #1;
    chk("disp_busy_ready_in", 256'(if_rr.ready_in), 256'(0));

    // Illegal selector: never accepted, sticky bad_sel.
    if_rr.core_sel_in = 2'd3;
    if_rr.core_ready = 3'b111;
    #1;
    chk("bad_ready_in",   256'(if_rr.ready_in), 256'(0));
    chk("bad_core_valid", 256'(if_rr.core_valid), 256'(0));
    chk("bad_sel_before", 256'(if_rr.bad_sel), 256'(0));
    tick();
    if_rr.valid_in = 1'b0;
    chk("bad_sel_set", 256'(if_rr.bad_sel), 256'(1));
    repeat (2) tick();
    chk("bad_sel_sticky", 256'(if_rr.bad_sel), 256'(1));

    // Ordered completion: core 1 answers first but must wait for core 0.
    if_ord.core_ready = 3'b111;
    if_ord.ready_out = 1'b1;
    if_ord.valid_in = 1'b1;
    if_ord.core_sel_in = 2'd0;
    if_ord.tag_in = 2'd0;
    #1;
    chk("ord_ready_in0",   256'(if_ord.ready_in), 256'(1));
    chk("ord_core_valid0", 256'(if_ord.core_valid), 256'(3'b001));
    tick();
    if_ord.core_sel_in = 2'd1;
    if_ord.tag_in = 2'd1;
    #1;
    chk("ord_core_valid1", 256'(if_ord.core_valid), 256'(3'b010));
    tick();
    if_ord.valid_in = 1'b0;
    if_ord.rsp_valid = 3'b010;
    #1;
    chk("ord_stall_rsp_ready", 256'(if_ord.rsp_ready), 256'(0));
    for (int w = 0; w < 4; w++) begin
      tick();
      chk("ord_wait_rsp_ready", 256'(if_ord.rsp_ready), 256'(0));
      chk("ord_wait_valid_out", 256'(if_ord.valid_out), 256'(0));
    end
    if_ord.rsp_valid = 3'b011;
    #1;
    chk("ord_head_rsp_ready", 256'(if_ord.rsp_ready), 256'(3'b001));
    tick();
    chk("ord_out0_valid", 256'(if_ord.valid_out), 256'(1));
    chk("ord_out0_tag",   256'(if_ord.tag_out), 256'(0));
    chk("ord_out0_core",  256'(if_ord.core_out), 256'(0));
    if_ord.rsp_valid = 3'b010;
    #1;
    chk("ord_next_rsp_ready", 256'(if_ord.rsp_ready), 256'(3'b010));
    tick();
    chk("ord_out1_tag",  256'(if_ord.tag_out), 256'(1));
    chk("ord_out1_core", 256'(if_ord.core_out), 256'(1));
    chk("ord_out1_data", 256'(if_ord.data_out), 256'(32'hE001));
    if_ord.rsp_valid = 3'b000;
    tick();
    chk("ord_drain", 256'(if_ord.valid_out), 256'(0));

    // Order FIFO full at 4 entries; one pop reopens dispatch.
    if_ord.valid_in = 1'b1;
    for (int d = 0; d < 4; d++) begin
      if_ord.core_sel_in = (d == 0) ? 2'd2 : (d == 2) ? 2'd1 : 2'd0;
      #1;
      chk("full_fill_ready_in", 256'(if_ord.ready_in), 256'(1));
      tick();
    end
    if_ord.core_sel_in = 2'd1;
    #1;
    chk("full_ready_in",   256'(if_ord.ready_in), 256'(0));
    chk("full_core_valid", 256'(if_ord.core_valid), 256'(0));
    tick();
    chk("full_ready_in_held", 256'(if_ord.ready_in), 256'(0));
    if_ord.rsp_valid = 3'b100;
    #1;
    chk("full_pop_rsp_ready", 256'(if_ord.rsp_ready), 256'(3'b100));
    tick();
    if_ord.rsp_valid = 3'b000;
    #1;
    chk("full_reopen_ready_in", 256'(if_ord.ready_in), 256'(1));
    chk("full_pop_core_out",    256'(if_ord.core_out), 256'(2));
    if_ord.valid_in = 1'b0;
    if_ord.rsp_valid = 3'b001;
    #1;
    chk("full_pop2_rsp_ready", 256'(if_ord.rsp_ready), 256'(3'b001));
    tick();
    if_ord.rsp_valid = 3'b000;
    if_ord.ready_out = 1'b0;
    tick();
    chk("pre_rst_valid_out", 256'(if_ord.valid_out), 256'(1));

    // Reset mid-operation with 2 queued entries and valid_out high.
    reset = 1'b0;
    #1;
    chk("mid_rst_valid_out", 256'(if_ord.valid_out), 256'(0));
    chk("mid_rst_core_out",  256'(if_ord.core_out), 256'(0));
    chk("mid_rst_bad_sel",   256'(if_rr.bad_sel), 256'(0));
    tick();
    reset = 1'b1;
    if_ord.ready_out = 1'b1;
    if_ord.valid_in = 1'b1;
    if_ord.core_sel_in = 2'd2;
    if_ord.tag_in = 2'd2;
    #1;
    chk("post_rst_ready_in",   256'(if_ord.ready_in), 256'(1));
    chk("post_rst_core_valid", 256'(if_ord.core_valid), 256'(3'b100));
    tick();
    if_ord.valid_in = 1'b0;
    if_ord.rsp_valid = 3'b100;
    #1;
    chk("post_rst_rsp_ready", 256'(if_ord.rsp_ready), 256'(3'b100));
    tick();
    if_ord.rsp_valid = 3'b000;
    chk("post_rst_valid_out", 256'(if_ord.valid_out), 256'(1));
    chk("post_rst_tag_out",   256'(if_ord.tag_out), 256'(2));
    chk("post_rst_core_out",  256'(if_ord.core_out), 256'(2));
    chk("post_rst_data_out",  256'(if_ord.data_out), 256'(32'hE002));
    tick();
    chk("post_rst_drain", 256'(if_ord.valid_out), 256'(0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
